// File: rtl/bist_pattern_harness.sv
// rtl/bist_pattern_harness.sv - self-running LFSR stimulus / MISR signature BIST harness
//
// Drives a DUT with LFSR patterns, captures the DUT response LATENCY cycles
// later and folds it into a MISR signature that is checked against golden.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active high
//   start         begin a run (sampled only in IDLE)
//   abort         cancel a run in RUN/DRAIN, no done
//   pattern_count number of patterns, sampled with start
//   golden        expected signature, compared in DONE
//   stim          stimulus to the DUT (0 when not running)
//   stim_valid    stim carries a live pattern this cycle
//   resp          DUT response
//   busy          high in RUN and DRAIN
//   done          one-cycle pulse at the end of a run
//   signature     MISR value, held until the next start
//   pass          signature == golden, registered at the end of DONE
module bist_pattern_harness #(
  parameter int              WIDTH   = 8,
  parameter int              CNT_W   = 8,
  parameter int              LATENCY = 0,
  parameter logic [WIDTH-1:0] POLY   = 8'hB8,
  parameter logic [WIDTH-1:0] SEED   = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] stim,
  output logic             stim_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       drain_cnt;
  logic             cap_valid;
  logic             abort_hit;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] sig_next;

  assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & POLY)};
  assign sig_next  = {signature[WIDTH-2:0], ^(signature & POLY)} ^ resp;
  assign abort_hit = abort && busy;

  // Capture strobe: stim_valid delayed by the DUT latency. The pipe is
  // flushed on abort so a later run never sees stale valids.
  generate
    if (LATENCY == 0) begin : g_comb_dut
      assign cap_valid = stim_valid;
    end else begin : g_pipe
      logic [LATENCY-1:0] valid_pipe;
      always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
          valid_pipe <= '0;
        end else begin
          valid_pipe <= (valid_pipe << 1) | LATENCY'(stim_valid);
        end
      end
      assign cap_valid = valid_pipe[LATENCY-1];
    end
  endgenerate

  always_comb begin
    state_n    = state;
    stim_valid = (state == S_RUN);
    stim       = (state == S_RUN) ? lfsr : '0;
    busy       = (state == S_RUN) || (state == S_DRAIN);
    done       = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = (pattern_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (remaining == CNT_W'(1)) begin
          state_n = (LATENCY == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (drain_cnt == 3'd0) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      remaining <= '0;
      drain_cnt <= '0;
      signature <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= pattern_count;
            lfsr      <= SEED;
            signature <= '0;
            pass      <= 1'b0;
          end
        end
        S_RUN: begin
          lfsr      <= lfsr_next;
          remaining <= remaining - CNT_W'(1);
          // Drain length counts down to zero, so load one less than LATENCY.
          drain_cnt <= 3'(LATENCY - 1);
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
        end
        S_DONE: begin
          pass <= (signature == golden);
        end
        default: begin
        end
      endcase
      // An aborted run keeps its partial signature untouched.
      if (cap_valid && !abort_hit) begin
        signature <= sig_next;
      end
      if (abort_hit) begin
        pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bist_pattern_harness.sv
// tb/tb_bist_pattern_harness.sv - scoreboard bench for bist_pattern_harness
module tb_bist_pattern_harness;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern_count;
  logic [7:0] golden;
  logic       resp_zero;

  logic [7:0] stim_a, resp_a, signature_a;
  logic       stim_valid_a, busy_a, done_a, pass_a;
  logic [7:0] stim_b, resp_b, signature_b;
  logic       stim_valid_b, busy_b, done_b, pass_b;
  logic [7:0] d1, d2, d3;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int nvalid_a, ndone_a, ndone_b, done_cyc_a, done_cyc_b, ndrain_b;
  logic busy_a_at_done;
  logic [7:0] first_stim_a;

  always #5 clk = ~clk;

  bist_pattern_harness #(.WIDTH(8), .CNT_W(8), .LATENCY(0), .POLY(8'hB8), .SEED(8'h01)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_count(pattern_count),
    .golden(golden), .stim(stim_a), .stim_valid(stim_valid_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .signature(signature_a), .pass(pass_a)
  );

  bist_pattern_harness #(.WIDTH(8), .CNT_W(8), .LATENCY(3), .POLY(8'hB8), .SEED(8'h01)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_count(pattern_count),
    .golden(golden), .stim(stim_b), .stim_valid(stim_valid_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .signature(signature_b), .pass(pass_b)
  );

  assign resp_a = resp_zero ? 8'h00 : stim_a;

  always @(posedge clk) begin
    d1 <= stim_b;
    d2 <= d1;
    d3 <= d2;
  end
  assign resp_b = d3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  // Scoreboard: every live stim of the LATENCY=0 instance must match the queue head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && stim_valid_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stim_unexpected got=%02h expected no pattern", stim_a);
      end else begin
        e = exp_q.pop_front();
        if (stim_a !== e) begin
          errors++;
          $display("FAIL stim_seq got=%02h expected=%02h", stim_a, e);
        end
      end
      checks++;
      if (stim_a === 8'h00) begin
        errors++;
        $display("FAIL stim_nonzero got=%02h expected nonzero", stim_a);
      end
    end
  end

  task automatic push_run(input int n, output logic [7:0] sig);
    logic [7:0] x;
    x   = 8'h01;
    sig = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x);
      sig = lfsr_step(sig) ^ x;
      x   = lfsr_step(x);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    pattern_count = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_watch(input int n, input int lim);
    nvalid_a = 0; ndone_a = 0; ndone_b = 0; ndrain_b = 0;
    done_cyc_a = -1; done_cyc_b = -1; busy_a_at_done = 1'bx; first_stim_a = 8'hxx;
    do_start(n);
    for (int c = 1; c <= lim; c++) begin
      if (c == 1) first_stim_a = stim_a;
      if (stim_valid_a) nvalid_a++;
      if (done_a) begin ndone_a++; done_cyc_a = c; busy_a_at_done = busy_a; end
      if (done_b) begin ndone_b++; done_cyc_b = c; end
      if (busy_b && !stim_valid_b) ndrain_b++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern_count = 8'h00; golden = 8'h00; resp_zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stim_a, stim_valid_a, busy_a, done_a, signature_a, pass_a} !== 20'h0) begin
      errors++; $display("FAIL reset_a got=%h expected=0", {stim_a, stim_valid_a, busy_a, done_a, signature_a, pass_a});
    end
    checks++;
    if ({stim_b, stim_valid_b, busy_b, done_b, signature_b, pass_b} !== 20'h0) begin
      errors++; $display("FAIL reset_b got=%h expected=0", {stim_b, stim_valid_b, busy_b, done_b, signature_b, pass_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_run6;
    logic [7:0] s;
    push_run(6, s);
    golden = s;
    run_watch(6, 30);
    checks++; if (nvalid_a !== 6) begin errors++; $display("FAIL run6_valid_cycles got=%0d expected=6", nvalid_a); end
    checks++; if (first_stim_a !== 8'h01) begin errors++; $display("FAIL run6_first_stim got=%02h expected=01", first_stim_a); end
    checks++; if (ndone_a !== 1) begin errors++; $display("FAIL run6_done_pulses got=%0d expected=1", ndone_a); end
    checks++; if (done_cyc_a !== 7) begin errors++; $display("FAIL run6_done_cycle_a got=%0d expected=7", done_cyc_a); end
    checks++; if (busy_a_at_done !== 1'b0) begin errors++; $display("FAIL run6_busy_at_done got=%b expected=0", busy_a_at_done); end
    checks++; if (signature_a !== s) begin errors++; $display("FAIL run6_sig_a got=%02h expected=%02h", signature_a, s); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL run6_pass_a got=%b expected=1", pass_a); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run6_queue_left got=%0d expected=0", exp_q.size()); end
    checks++; if (ndrain_b !== 3) begin errors++; $display("FAIL lat3_drain_cycles got=%0d expected=3", ndrain_b); end
    checks++; if (done_cyc_b !== 10) begin errors++; $display("FAIL lat3_done_cycle got=%0d expected=10", done_cyc_b); end
    checks++; if (ndone_b !== 1) begin errors++; $display("FAIL lat3_done_pulses got=%0d expected=1", ndone_b); end
    checks++; if (signature_b !== s) begin errors++; $display("FAIL lat3_sig got=%02h expected=%02h", signature_b, s); end
  endtask

  task automatic test_golden;
    logic [7:0] s;
    push_run(1, s);
    golden = 8'h00;
    run_watch(1, 12);
    checks++; if (signature_a !== 8'h01) begin errors++; $display("FAIL cnt1_sig got=%02h expected=01", signature_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL cnt1_pass got=%b expected=0", pass_a); end
    push_run(2, s);
    golden = 8'h00;
    run_watch(2, 12);
    checks++; if (signature_a !== 8'h00) begin errors++; $display("FAIL cnt2_sig got=%02h expected=00", signature_a); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL cnt2_pass_g00 got=%b expected=1", pass_a); end
    checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL cnt2_pass_lat3 got=%b expected=1", pass_b); end
    push_run(2, s);
    golden = 8'h01;
    run_watch(2, 12);
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL cnt2_pass_g01 got=%b expected=0", pass_a); end
  endtask

  task automatic test_zero_resp;
    logic [7:0] s;
    push_run(255, s);
    resp_zero = 1'b1;
    golden = 8'h00;
    run_watch(255, 266);
    resp_zero = 1'b0;
    checks++; if (nvalid_a !== 255) begin errors++; $display("FAIL zero_valid_cycles got=%0d expected=255", nvalid_a); end
    checks++; if (done_cyc_a !== 256) begin errors++; $display("FAIL zero_done_cycle got=%0d expected=256", done_cyc_a); end
    checks++; if (signature_a !== 8'h00) begin errors++; $display("FAIL zero_sig got=%02h expected=00", signature_a); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL zero_pass got=%b expected=1", pass_a); end
    checks++; if (signature_b !== s) begin errors++; $display("FAIL lat3_sig255 got=%02h expected=%02h", signature_b, s); end
  endtask

  task automatic test_count_zero;
    golden = 8'h00;
    run_watch(0, 8);
    checks++; if (nvalid_a !== 0) begin errors++; $display("FAIL cnt0_valid got=%0d expected=0", nvalid_a); end
    checks++; if (done_cyc_a !== 1) begin errors++; $display("FAIL cnt0_done_cycle got=%0d expected=1", done_cyc_a); end
    checks++; if (done_cyc_b !== 1) begin errors++; $display("FAIL cnt0_done_cycle_lat3 got=%0d expected=1", done_cyc_b); end
    checks++; if (signature_a !== 8'h00) begin errors++; $display("FAIL cnt0_sig got=%02h expected=00", signature_a); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL cnt0_pass got=%b expected=1", pass_a); end
  endtask

  task automatic test_abort;
    logic [7:0] s;
    int dones;
    push_run(6, s);
    do_start(6);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({busy_a, stim_valid_a, busy_b, stim_valid_b} !== 4'b0) begin
      errors++; $display("FAIL abort_idle got=%b expected=0000", {busy_a, stim_valid_a, busy_b, stim_valid_b});
    end
    checks++; if (exp_q.size() != 3) begin errors++; $display("FAIL abort_patterns_left got=%0d expected=3", exp_q.size()); end
    exp_q.delete();
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_a || done_b) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d expected=0", dones); end
    push_run(6, s);
    golden = s;
    run_watch(6, 20);
    checks++; if (first_stim_a !== 8'h01) begin errors++; $display("FAIL rerun_first_stim got=%02h expected=01", first_stim_a); end
    checks++; if (signature_a !== s) begin errors++; $display("FAIL rerun_sig got=%02h expected=%02h", signature_a, s); end
    checks++; if (ndone_a !== 1) begin errors++; $display("FAIL rerun_done got=%0d expected=1", ndone_a); end
  endtask

  task automatic test_reset_drain;
    logic [7:0] s;
    int dones;
    bit seen;
    push_run(6, s);
    do_start(6);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (busy_b && !stim_valid_b) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drain_timeout got=no DRAIN expected=DRAIN within 20 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stim_b, stim_valid_b, busy_b, done_b, signature_b, pass_b} !== 20'h0) begin
      errors++; $display("FAIL rst_drain_outputs got=%h expected=0", {stim_b, stim_valid_b, busy_b, done_b, signature_b, pass_b});
    end
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_b) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rst_drain_no_done got=%0d expected=0", dones); end
    checks++; if (signature_b !== 8'h00) begin errors++; $display("FAIL rst_drain_pipe_empty got=%02h expected=00", signature_b); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_run6();
    test_golden();
    test_zero_resp();
    test_count_zero();
    test_abort();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_pattern_harness.md
Name: bist_pattern_harness

Overview:
Parametrised on-chip built-in self-test harness for Tiny Tapeout user designs. It drives a DUT input bus with LFSR pseudo-random patterns and captures the DUT response after a fixed latency. Responses are compressed into a MISR signature, which is compared against a golden value. It generalises the static bench harness to a self-running, width- and latency-configurable sequencer that runs on silicon without cocotb.

Parameters:
WIDTH, 8, stimulus/response bus width (2..32)
CNT_W, 8, width of pattern_count; max run length 2^CNT_W-1
LATENCY, 0, DUT response delay in cycles (0..7); 0 = combinational DUT
POLY, 8'hB8, LFSR/MISR feedback tap mask (WIDTH bits)
SEED, 8'h01, LFSR start value (WIDTH bits, nonzero)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
start  in  1  begin run; sampled only in IDLE
abort  in  1  cancel run, return to IDLE without done
pattern_count  in  CNT_W  number of patterns; sampled with start
golden  in  WIDTH  expected signature; compared in DONE
stim  out  WIDTH  stimulus to DUT
stim_valid  out  1  stim holds a live pattern this cycle
resp  in  WIDTH  DUT response
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of run
signature  out  WIDTH  MISR value; held after done until next start
pass  out  1  signature==golden; valid from done, held until next start

Behaviour:
- One clock. Reset is synchronous and active high.
- Reset values: stim=0, stim_valid=0, busy=0, done=0, signature=0, pass=0. State=IDLE, LFSR=SEED, valid pipe cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 and pattern_count!=0 -> RUN next cycle. On that edge: latch count, LFSR<=SEED, signature<=0, pass<=0.
- IDLE: start=1 and pattern_count==0 -> DONE next cycle with signature=0.
- RUN:
  - stim=LFSR and stim_valid=1 every cycle.
  - LFSR next = {lfsr[WIDTH-2:0], ^(lfsr & POLY)}.
  - Remaining count decrements each cycle. After exactly pattern_count RUN cycles -> DRAIN; if LATENCY==0 -> DONE directly.
- Capture: stim_valid passes through a LATENCY-deep shift pipe. When the pipe output (LATENCY=0: stim_valid itself) is 1, resp is sampled that cycle and signature next = {sig[WIDTH-2:0], ^(sig & POLY)} XOR resp.
- DRAIN: stim_valid=0, stim=0. Captures continue until the pipe is empty -> DONE. DRAIN lasts exactly LATENCY cycles.
- DONE: held one cycle. done=1, pass=(signature==golden) registered at the end of the cycle, busy=0 -> IDLE.
- abort=1 in RUN or DRAIN -> IDLE next cycle:
  - stim_valid=0 and pipe cleared.
  - no done; signature holds its partial value; pass=0.
  - abort in IDLE or DONE has no effect.
- start while busy or in DONE: ignored.
- abort and start in the same IDLE cycle: start wins.
- Reset mid-run: immediate return to all reset values; no done.
- All arithmetic is modulo 2^WIDTH and modulo 2^CNT_W; there are no saturating paths.

Test Plan:
- WIDTH=8, LATENCY=0, resp tied to stim, start with count=6 -> stim_valid high exactly 6 cycles. stim sequence 01,02,04,08,10,21. done pulses once, busy falls the same cycle.
- Loopback, count=1 -> signature=01. Count=2 -> signature=00. golden=00 -> pass=1; golden=01 -> pass=0.
- LATENCY=3, resp = stim delayed 3 cycles by a bench register chain, count=6 -> DRAIN exactly 3 cycles. Signature equals the LATENCY=0 loopback result for count=6; done 10 cycles after start.
- resp held at 00, count=255 -> signature=00, pass=1 with golden=00. LFSR never reaches 00 during the run.
- start with count=0 -> done on the next cycle, stim_valid never asserted, signature=00.
- abort on RUN cycle 3 of count=6 -> no done, busy=0 next cycle, stim_valid=0. A following start reruns from SEED=01.
- rst asserted in DRAIN -> all outputs 0 next cycle, no done, pipe empty.
